// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared constants, FSM encoding and destination decode for the FIFO arbiter.
package fifo_arb_pkg;

    localparam int NUM_PORTS  = 4;
    localparam int DATA_WIDTH = 6;
    localparam int DEST_LSB   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        CAPT = 2'd2,
        PUSH = 2'd3
    } state_t;

    function automatic logic [1:0] get_dest(input logic [DATA_WIDTH-1:0] w);
        return 2'(w >> DEST_LSB);
    endfunction

endpackage

// File: rtl/rr_grant4.sv
// rr_grant4: combinational 4-way round-robin picker; lowest-index fixed priority under ARB_FIXED_PRIO_EN.
module rr_grant4
    import fifo_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic [1:0]           ptr,
    output logic [1:0]           grant,
    output logic                 valid
);

    logic [1:0] base;
    logic [3:0] rot;
    logic [1:0] off;

`ifdef ARB_FIXED_PRIO_EN
    assign base = 2'd0;
`else
    assign base = ptr;
`endif

    // Rotate so the search always starts at bit 0, then undo the rotation on the index.
    always_comb begin
        rot   = (base == 2'd0) ? req :
                (base == 2'd1) ? {req[0], req[3:1]} :
                (base == 2'd2) ? {req[1:0], req[3:2]} :
                                 {req[2:0], req[3]};
        off   = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
        grant = off + base;
        valid = |rot;
    end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: moves one word per transaction from a round-robin-picked source FIFO to the destination FIFO named in the word.
// Optional build macro ARB_FIXED_PRIO_EN selects lowest-index fixed priority instead of round-robin.
module fifo_rr_arbiter
    import fifo_arb_pkg::*;
(
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            in_empty,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
    output logic [NUM_PORTS-1:0]            in_pop,
    input  logic [NUM_PORTS-1:0]            out_pausa,
    output logic [NUM_PORTS-1:0]            out_push,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic [1:0]                      active_src,
    output logic                            arb_idle,
    output logic [7:0]                      words_moved
);

    state_t                  state_q, state_d;
    logic [1:0]              rr_ptr_q, rr_ptr_d;
    logic [1:0]              src_q, src_d;
    logic [1:0]              dest_q, dest_d;
    logic [DATA_WIDTH-1:0]   hold_q, hold_d;
    logic [NUM_PORTS-1:0]    in_pop_q, in_pop_d;
    logic [NUM_PORTS-1:0]    out_push_q, out_push_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic                    arb_idle_q, arb_idle_d;
    logic [7:0]              words_q, words_d;
    logic [1:0]              gnt;
    logic                    gnt_valid;
    logic [DATA_WIDTH-1:0]   sel_word;

    rr_grant4 u_grant (
        .req   (~in_empty),
        .ptr   (rr_ptr_q),
        .grant (gnt),
        .valid (gnt_valid)
    );

    assign sel_word = in_data[src_q*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        src_d      = src_q;
        dest_d     = dest_q;
        hold_d     = hold_q;
        in_pop_d   = '0;
        out_push_d = '0;
        out_data_d = out_data_q;
        words_d    = words_q;
        case (state_q)
            IDLE: if (gnt_valid) begin
                state_d  = POP;
                src_d    = gnt;
                in_pop_d = 4'b0001 << gnt;
`ifdef ARB_FIXED_PRIO_EN
                rr_ptr_d = 2'd0;
`else
                rr_ptr_d = gnt + 2'd1;
`endif
            end
            POP:  state_d = CAPT;
            CAPT: begin
                hold_d  = sel_word;
                dest_d  = get_dest(sel_word);
                state_d = PUSH;
            end
            PUSH: if (!out_pausa[dest_q]) begin
                out_push_d = 4'b0001 << dest_q;
                out_data_d = hold_q;
                words_d    = words_q + 8'd1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        arb_idle_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            src_q      <= '0;
            dest_q     <= '0;
            hold_q     <= '0;
            in_pop_q   <= '0;
            out_push_q <= '0;
            out_data_q <= '0;
            arb_idle_q <= 1'b1;
            words_q    <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            src_q      <= src_d;
            dest_q     <= dest_d;
            hold_q     <= hold_d;
            in_pop_q   <= in_pop_d;
            out_push_q <= out_push_d;
            out_data_q <= out_data_d;
            arb_idle_q <= arb_idle_d;
            words_q    <= words_d;
        end
    end

    assign in_pop      = in_pop_q;
    assign out_push    = out_push_q;
    assign out_data    = out_data_q;
    assign active_src  = src_q;
    assign arb_idle    = arb_idle_q;
    assign words_moved = words_q;

endmodule
